// File: rtl/treasure_pkg.sv
// Shared definitions for the treasure colour detector: the colour codes used on the
// Arduino pins, the controller state encoding, and a small counter helper.
package treasure_pkg;

  // Colour codes as presented on the COLOR pins.
  localparam logic [1:0] COLOR_NONE    = 2'b00;
  localparam logic [1:0] COLOR_BLUE    = 2'b01;
  localparam logic [1:0] COLOR_RED     = 2'b10;
  localparam logic [1:0] COLOR_INCONCL = 2'b11;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle,
    StSkip,
    StCollect,
    StSend,
    StWaitAckHi,
    StWaitAckLo
  } state_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for level inputs arriving from the Arduino.
module sync_2ff (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/treasure_detect_ctrl.sv
// Per-request colour measurement controller. On a START request it skips a partial
// frame, samples the classifier once per frame, commits a colour after enough
// identical frames (or "inconclusive" after too many), and hands the result to the
// Arduino over a 4-phase VALID/ACK handshake.
module treasure_detect_ctrl
  import treasure_pkg::*;
#(
  parameter int unsigned AGREE_FRAMES   = 3,
  parameter int unsigned TIMEOUT_FRAMES = 30,
  parameter int unsigned SKIP_FRAMES    = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ACK,
  input  logic       VGA_VSYNC_NEG,
  input  logic [7:0] PROC_RESULT,
  output logic [1:0] COLOR,
  output logic       VALID,
  output logic       BUSY,
  output logic       CAPTURE_STB
);

  localparam logic [3:0] AGREE_CNT   = 4'(AGREE_FRAMES);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_FRAMES);
  localparam logic [3:0] SKIP_CNT    = 4'(SKIP_FRAMES);

  logic       start_sync;
  logic       ack_sync;
  logic       start_sync_q;
  logic       vsync_q;
  logic       start_rise;
  logic       frame_end;
  logic [1:0] sample_code;

  state_e     state_q;
  logic [7:0] frame_cnt_q;
  logic [3:0] run_cnt_q;
  logic [2:0] skip_cnt_q;
  logic [1:0] last_code_q;

  logic [7:0] frame_next;
  logic [3:0] run_next;
  logic [2:0] skip_next;
  logic       agree_hit;
  logic       timeout_hit;
  logic       skip_done;

  // Low classifier bits carry nothing we need.
  logic       unused_proc_bits;
  assign unused_proc_bits = ^PROC_RESULT[5:0];

  sync_2ff u_sync_start (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (START),
    .q     (start_sync)
  );

  sync_2ff u_sync_ack (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (ACK),
    .q     (ack_sync)
  );

  // Delay copies for START edge detection and VSYNC falling-edge (frame end) detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_sync_q <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      start_sync_q <= start_sync;
      vsync_q      <= VGA_VSYNC_NEG;
    end
  end

  assign start_rise  = start_sync & ~start_sync_q;
  assign frame_end   = vsync_q & ~VGA_VSYNC_NEG;
  assign sample_code = PROC_RESULT[7:6];

  // Counter look-ahead for the current sample and skip frame.
  always_comb begin
    frame_next  = frame_cnt_q + 8'd1;
    run_next    = (sample_code == last_code_q) ? sat_inc4(run_cnt_q, AGREE_CNT) : 4'd1;
    agree_hit   = (run_next == AGREE_CNT);
    timeout_hit = (frame_next == TIMEOUT_CNT);
    skip_next   = skip_cnt_q + 3'd1;
    skip_done   = ({1'b0, skip_next} == SKIP_CNT);
  end

  // Controller FSM with registered outputs. CAPTURE_STB doubles as the "sample now"
  // flag: it is set on the frame-end edge so it is high exactly on the cycle where
  // PROC_RESULT carries that frame's code.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      COLOR       <= COLOR_NONE;
      VALID       <= 1'b0;
      BUSY        <= 1'b0;
      CAPTURE_STB <= 1'b0;
      frame_cnt_q <= 8'd0;
      run_cnt_q   <= 4'd0;
      skip_cnt_q  <= 3'd0;
      last_code_q <= COLOR_NONE;
    end else begin
      CAPTURE_STB <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_rise) begin
            frame_cnt_q <= 8'd0;
            run_cnt_q   <= 4'd0;
            skip_cnt_q  <= 3'd0;
            last_code_q <= COLOR_NONE;
            BUSY        <= 1'b1;
            state_q     <= (SKIP_FRAMES == 0) ? StCollect : StSkip;
          end
        end
        StSkip: begin
          if (frame_end) begin
            if (skip_done) begin
              state_q <= StCollect;
            end else begin
              skip_cnt_q <= skip_next;
            end
          end
        end
        StCollect: begin
          CAPTURE_STB <= frame_end;
          if (CAPTURE_STB) begin
            frame_cnt_q <= frame_next;
            run_cnt_q   <= run_next;
            last_code_q <= sample_code;
            // Agreement takes priority over a coincident timeout.
            if (agree_hit) begin
              COLOR   <= sample_code;
              state_q <= StSend;
            end else if (timeout_hit) begin
              COLOR   <= COLOR_INCONCL;
              state_q <= StSend;
            end
          end
        end
        StSend: begin
          VALID   <= 1'b1;
          state_q <= StWaitAckHi;
        end
        StWaitAckHi: begin
          if (ack_sync) begin
            VALID   <= 1'b0;
            state_q <= StWaitAckLo;
          end
        end
        StWaitAckLo: begin
          if (!ack_sync) begin
            BUSY    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          VALID   <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_treasure_detect_ctrl.sv
// Directed bench for treasure_detect_ctrl (AGREE=3, TIMEOUT=8, SKIP=1). A table of
// requests drives whole measurements; hand sequences cover latency, ignored START
// pulses and reset during a handshake.
module tb_treasure_detect_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic       ACK;
  logic       VGA_VSYNC_NEG;
  logic [7:0] PROC_RESULT;
  logic [1:0] COLOR;
  logic       VALID;
  logic       BUSY;
  logic       CAPTURE_STB;

  int checks = 0;
  int errors = 0;
  int caps   = 0;
  int base   = 0;

  treasure_detect_ctrl #(
    .AGREE_FRAMES   (3),
    .TIMEOUT_FRAMES (8),
    .SKIP_FRAMES    (1)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .ACK           (ACK),
    .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
    .PROC_RESULT   (PROC_RESULT),
    .COLOR         (COLOR),
    .VALID         (VALID),
    .BUSY          (BUSY),
    .CAPTURE_STB   (CAPTURE_STB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Capture pulse counter.
  always @(posedge CLK) if (CAPTURE_STB === 1'b1) caps <= caps + 1;

  typedef struct {
    int unsigned n;      // collected frames after the skip frame
    logic [15:0] codes;  // frame codes, first code in [15:14]
    logic [1:0]  color;  // expected committed COLOR
    int unsigned ncap;   // expected CAPTURE_STB pulses
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_req();
    START = 1'b1;
    repeat (4) step();
    START = 1'b0;
    step();
    chk("busy_after_start", BUSY, 1);
  endtask

  // One video frame; the classifier drives its code only on the sample cycle.
  task automatic frame(input logic [1:0] code, input bit lat, input logic [1:0] exp);
    repeat (6) step();
    VGA_VSYNC_NEG = 1'b0;
    step();
    if (lat) chk("stb_on_sample", CAPTURE_STB, 1);
    PROC_RESULT = {code, 6'b101101};
    step();
    PROC_RESULT = 8'h00;
    if (lat) begin
      chk("commit_color", COLOR, exp);
      chk("valid_not_yet", VALID, 0);
    end
    step();
    if (lat) chk("valid_two_cycles", VALID, 1);
    repeat (2) step();
    VGA_VSYNC_NEG = 1'b1;
  endtask

  task automatic handshake(input logic [1:0] exp);
    ACK = 1'b1;
    repeat (2) step();
    chk("valid_hold_sync", VALID, 1);
    step();
    chk("valid_drop", VALID, 0);
    chk("busy_ack_lo", BUSY, 1);
    repeat (3) step();
    ACK = 1'b0;
    repeat (2) step();
    chk("busy_hold_sync", BUSY, 1);
    step();
    chk("busy_drop", BUSY, 0);
    chk("color_held", COLOR, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3, {2'b10, 2'b10, 2'b10, 10'd0}, 2'b10, 3};
    vecs[1] = '{5, {2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 6'd0}, 2'b01, 5};
    vecs[2] = '{5, {2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 6'd0}, 2'b01, 5};
    vecs[3] = '{8, {2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01}, 2'b11, 8};
    vecs[4] = '{8, {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10}, 2'b11, 8};
    vecs[5] = '{8, {2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10}, 2'b10, 8};
    vecs[6] = '{3, {2'b11, 2'b11, 2'b11, 10'd0}, 2'b11, 3};
    vecs[7] = '{3, {2'b00, 2'b00, 2'b00, 10'd0}, 2'b00, 3};

    RESET = 1'b1;
    START = 1'b0;
    ACK = 1'b0;
    VGA_VSYNC_NEG = 1'b1;
    PROC_RESULT = 8'h00;
    repeat (3) step();
    chk("rst_color", COLOR, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_stb", CAPTURE_STB, 0);
    RESET = 1'b0;
    step();

    // Table-driven requests.
    for (int v = 0; v < NV; v++) begin
      logic [15:0] cw;
      cw = vecs[v].codes;
      base = caps;
      start_req();
      frame(2'b10, 1'b0, 2'b00);
      for (int k = 0; k < int'(vecs[v].n); k++) frame(cw[15 - 2 * k -: 2], 1'b0, 2'b00);
      chk($sformatf("vec%0d_valid", v), VALID, 1);
      chk($sformatf("vec%0d_color", v), COLOR, vecs[v].color);
      chk($sformatf("vec%0d_caps", v), caps - base, vecs[v].ncap);
      frame(2'b01, 1'b0, 2'b00);
      chk($sformatf("vec%0d_no_extra_cap", v), caps - base, vecs[v].ncap);
      chk($sformatf("vec%0d_color_stable", v), COLOR, vecs[v].color);
      handshake(vecs[v].color);
    end

    // START pulses during COLLECT and WAIT_ACK_HI are ignored.
    base = caps;
    start_req();
    frame(2'b10, 1'b0, 2'b00);
    frame(2'b10, 1'b0, 2'b00);
    frame(2'b10, 1'b0, 2'b00);
    start_req();
    frame(2'b10, 1'b1, 2'b10);
    chk("ign_caps", caps - base, 3);
    start_req();
    chk("ign_valid_hold", VALID, 1);
    chk("ign_color_hold", COLOR, 2'b10);
    handshake(2'b10);

    // Fresh request afterwards starts from cleared counters.
    base = caps;
    start_req();
    frame(2'b10, 1'b0, 2'b00);
    frame(2'b01, 1'b0, 2'b00);
    frame(2'b01, 1'b0, 2'b00);
    frame(2'b01, 1'b1, 2'b01);
    chk("fresh_caps", caps - base, 3);
    handshake(2'b01);

    // Reset while VALID is high discards the result.
    start_req();
    frame(2'b10, 1'b0, 2'b00);
    frame(2'b10, 1'b0, 2'b00);
    frame(2'b10, 1'b0, 2'b00);
    frame(2'b10, 1'b0, 2'b00);
    chk("pre_rst_valid", VALID, 1);
    RESET = 1'b1;
    step();
    chk("midrst_valid", VALID, 0);
    chk("midrst_color", COLOR, 0);
    chk("midrst_busy", BUSY, 0);
    RESET = 1'b0;
    step();
    base = caps;
    ACK = 1'b1;
    repeat (5) step();
    chk("post_rst_ack_valid", VALID, 0);
    chk("post_rst_ack_busy", BUSY, 0);
    ACK = 1'b0;
    repeat (5) step();
    frame(2'b10, 1'b0, 2'b00);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_caps", caps - base, 0);
    chk("post_rst_color", COLOR, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
